// File: rtl/fifo_pkg.sv
// Shared constants and types for the threshold FIFO family.
// Sizing helpers are functions because the address width is a module parameter.
package fifo_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    // Below this address width the RAM is small enough to live in fabric registers.
    localparam int BRAM_MIN_ADDR_BITS = 6;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic int count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// Deep configurations read the array straight into the output register (block RAM style).
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (ADDR_BITS >= BRAM_MIN_ADDR_BITS) begin : g_block
            always_ff @(posedge clk or negedge rst) begin
                if (rst == RST_ACTIVE) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_dist
            // Asynchronous array lookup followed by a register maps onto LUT RAM.
            logic [WIDTH-1:0] rd_word;
            assign rd_word = mem[rd_addr];

            always_ff @(posedge clk or negedge rst) begin
                if (rst == RST_ACTIVE) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/threshold_sync_fifo.sv
// Single-clock FIFO with registered consumer/producer threshold handshakes
// (M_Ready / S_Ready), occupancy flags and sticky over/underflow errors.
module threshold_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Next_Reg,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic [ADDR_BITS:0]   M_count,
    output logic                 M_Ready,
    input  logic [ADDR_BITS:0]   S_count,
    output logic                 S_Ready,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   data_count,
    output logic                 ovf_err,
    output logic                 udf_err
);

    localparam int DEPTH = depth_of(ADDR_BITS);
    localparam int CW    = count_width(ADDR_BITS);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 wr_accept;
    logic                 rd_accept;
    fifo_op_e             op;
    logic [CW-1:0]        count_next;
    logic [CW:0]          s_sum;
    logic                 m_ready_next;
    logic                 s_ready_next;

    // Accept decisions use pre-edge flags; a flush suppresses both requests.
    always_comb begin
        wr_accept    = wr_en && !full && !Next_Reg;
        rd_accept    = rd_en && !empty && !Next_Reg;
        op           = fifo_op_e'({wr_accept, rd_accept});
        count_next   = data_count;
        case (op)
            OP_WRITE: count_next = data_count + CW'(1);
            OP_READ:  count_next = data_count - CW'(1);
            default:  count_next = data_count;
        endcase
        s_sum        = {1'b0, data_count} + {1'b0, S_count};
        s_ready_next = (s_sum <= DEPTH_SUM);
        m_ready_next = (data_count >= M_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout_valid <= 1'b0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else if (Next_Reg) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout_valid <= 1'b0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            data_count <= count_next;
            full       <= (count_next == DEPTH_CNT);
            empty      <= (count_next == '0);
            dout_valid <= rd_accept;
            if (wr_en && full) begin
                ovf_err <= 1'b1;
            end
            if (rd_en && empty) begin
                udf_err <= 1'b1;
            end
        end
    end

    // Thresholds look at the registered count, so they trail it by one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            M_Ready <= 1'b0;
            S_Ready <= 1'b1;
        end else begin
            M_Ready <= m_ready_next;
            S_Ready <= s_ready_next;
        end
    end

    sdp_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_threshold_sync_fifo.sv
// Directed testbench for threshold_sync_fifo at DEPTH=16, WIDTH=8.
module tb_threshold_sync_fifo;

    localparam int WIDTH     = 8;
    localparam int ADDR_BITS = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 Next_Reg = 1'b0;
    logic [WIDTH-1:0]     din = '0;
    logic                 wr_en = 1'b0;
    logic                 rd_en = 1'b0;
    logic [ADDR_BITS:0]   M_count = 5'd5;
    logic [ADDR_BITS:0]   S_count = 5'd4;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic                 M_Ready;
    logic                 S_Ready;
    logic                 full;
    logic                 empty;
    logic [ADDR_BITS:0]   data_count;
    logic                 ovf_err;
    logic                 udf_err;

    int checks   = 0;
    int failures = 0;

    threshold_sync_fifo #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Next_Reg   (Next_Reg),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .M_count    (M_count),
        .M_Ready    (M_Ready),
        .S_count    (S_count),
        .S_Ready    (S_Ready),
        .full       (full),
        .empty      (empty),
        .data_count (data_count),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with both requests active
        rst = 1'b0; wr_en = 1'b1; rd_en = 1'b1; din = 8'h33;
        repeat (3) tick();
        check("rst_count", 32'(data_count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dvalid", 32'(dout_valid), 32'd0);
        check("rst_mready", 32'(M_Ready), 32'd0);
        check("rst_sready", 32'(S_Ready), 32'd1);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_udf", 32'(udf_err), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;
        tick();

        // Fill 16 words, tracking thresholds one edge behind the count
        for (int k = 1; k <= 16; k++) begin
            din = 8'(k - 1); wr_en = 1'b1;
            tick();
            check($sformatf("fill_count_%0d", k), 32'(data_count), 32'(k));
            check($sformatf("fill_mready_%0d", k), 32'(M_Ready), 32'(k >= 6));
            check($sformatf("fill_sready_%0d", k), 32'(S_Ready), 32'(k <= 13));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf_clear", 32'(ovf_err), 32'd0);
        din = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_count", 32'(data_count), 32'd16);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            check($sformatf("drain_dout_%0d", i), 32'(dout), 32'(i));
            check($sformatf("drain_valid_%0d", i), 32'(dout_valid), 32'd1);
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(data_count), 32'd0);
        tick();
        check("idle_valid", 32'(dout_valid), 32'd0);
        check("idle_dout_hold", 32'(dout), 32'h0F);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_set", 32'(udf_err), 32'd1);
        check("udf_no_valid", 32'(dout_valid), 32'd0);
        check("udf_dout_hold", 32'(dout), 32'h0F);
        check("ovf_sticky", 32'(ovf_err), 32'd1);

        // Threshold boundaries at empty
        S_count = 5'd17;
        tick();
        check("sready_17", 32'(S_Ready), 32'd0);
        S_count = 5'd16;
        tick();
        check("sready_16", 32'(S_Ready), 32'd1);
        S_count = 5'd4;
        M_count = 5'd0;
        tick();
        check("mready_zero", 32'(M_Ready), 32'd1);
        M_count = 5'd5;
        tick();
        check("mready_back", 32'(M_Ready), 32'd0);

        // Flush clears errors
        Next_Reg = 1'b1;
        tick();
        Next_Reg = 1'b0;
        check("flush_ovf", 32'(ovf_err), 32'd0);
        check("flush_udf", 32'(udf_err), 32'd0);

        // Simultaneous at empty: write taken, read rejected
        din = 8'h40; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("both0_count", 32'(data_count), 32'd1);
        check("both0_udf", 32'(udf_err), 32'd1);
        check("both0_valid", 32'(dout_valid), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            din = 8'(8'h40 + j);
            tick();
        end
        wr_en = 1'b0;
        check("count7", 32'(data_count), 32'd7);

        // Simultaneous at count 7
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h47;
        tick();
        check("both7a_count", 32'(data_count), 32'd7);
        check("both7a_dout", 32'(dout), 32'h40);
        check("both7a_valid", 32'(dout_valid), 32'd1);
        din = 8'h48;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("both7b_count", 32'(data_count), 32'd7);
        check("both7b_dout", 32'(dout), 32'h41);

        // Top up to full, then simultaneous at full
        for (int j = 0; j < 9; j++) begin
            din = 8'(8'h49 + j); wr_en = 1'b1;
            tick();
        end
        check("refill_full", 32'(full), 32'd1);
        din = 8'hEE; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("bothF_count", 32'(data_count), 32'd15);
        check("bothF_dout", 32'(dout), 32'h42);
        check("bothF_ovf", 32'(ovf_err), 32'd1);
        check("bothF_full", 32'(full), 32'd0);

        // Read down to 9; the dropped 0xEE must never appear
        for (int j = 0; j < 6; j++) begin
            rd_en = 1'b1;
            tick();
            check($sformatf("order_dout_%0d", j), 32'(dout), 32'(8'h43 + j));
        end
        rd_en = 1'b0;
        check("count9", 32'(data_count), 32'd9);
        check("count9_udf", 32'(udf_err), 32'd1);

        // Flush together with a write
        Next_Reg = 1'b1; wr_en = 1'b1; din = 8'h99;
        tick();
        Next_Reg = 1'b0; wr_en = 1'b0;
        check("flush2_count", 32'(data_count), 32'd0);
        check("flush2_empty", 32'(empty), 32'd1);
        check("flush2_ovf", 32'(ovf_err), 32'd0);
        check("flush2_udf", 32'(udf_err), 32'd0);
        check("flush2_valid", 32'(dout_valid), 32'd0);
        check("flush2_dout", 32'(dout), 32'h48);
        check("flush2_mready_lag", 32'(M_Ready), 32'd1);
        tick();
        check("flush2_mready", 32'(M_Ready), 32'd0);
        check("flush2_sready", 32'(S_Ready), 32'd1);
        check("flush2_no_write", 32'(data_count), 32'd0);
        din = 8'hAA; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("flush2_first", 32'(dout), 32'hAA);
        check("flush2_first_valid", 32'(dout_valid), 32'd1);

        // Asynchronous reset between edges during a burst
        for (int j = 0; j < 3; j++) begin
            din = 8'(8'h10 + j); wr_en = 1'b1;
            tick();
        end
        check("burst_count", 32'(data_count), 32'd3);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(data_count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_sready", 32'(S_Ready), 32'd1);
        wr_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        din = 8'h55; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("post_rst_count", 32'(data_count), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_dout", 32'(dout), 32'h55);
        check("post_rst_valid", 32'(dout_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
